// File: rtl/fifo_pkg.sv
// Shared constants and FSM state encoding for the FIFO burst reader.
package fifo_pkg;

    localparam int DEPTH         = 16;
    localparam int WIDTH         = 8;
    localparam int POINTER_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_burst_reader_if.sv
// FIFO read port plus downstream valid/ready stream; master is the reader side.
interface fifo_burst_reader_if #(
    parameter int WIDTH         = fifo_pkg::WIDTH,
    parameter int POINTER_WIDTH = fifo_pkg::POINTER_WIDTH
);
    import fifo_pkg::*;

    logic [POINTER_WIDTH:0] fifo_count;
    logic                   fifo_empty;
    logic                   fifo_rd_en;
    logic [WIDTH-1:0]       fifo_rd_data;
    logic                   m_valid;
    logic                   m_ready;
    logic [WIDTH-1:0]       m_data;

    modport master (
        input  fifo_count, fifo_empty, fifo_rd_data, m_ready,
        output fifo_rd_en, m_valid, m_data
    );

    modport slave (
        output fifo_count, fifo_empty, fifo_rd_data, m_ready,
        input  fifo_rd_en, m_valid, m_data
    );

endinterface

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order buffer that absorbs the FIFO's registered read latency.
module fifo_skid_buf #(
    parameter int WIDTH = fifo_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       occ,
    output logic [WIDTH-1:0] head
);
    import fifo_pkg::*;

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       occ_q, occ_d;

    // Simultaneous push and pop keeps occupancy and shifts the tail forward.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) head_d = push_data;
                else               tail_d = push_data;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    head_d = push_data;
                end else begin
                    head_d = tail_q;
                    tail_d = push_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign occ  = occ_q;
    assign head = head_q;

    a_no_overflow:  assert property (@(posedge clk) disable iff (reset) !(push && !pop && occ_q == 2'd2));
    a_no_underflow: assert property (@(posedge clk) disable iff (reset) !(pop && occ_q == 2'd0));

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains the FIFO in threshold-triggered bursts (or on flush) onto a valid/ready stream.
module fifo_burst_reader #(
    parameter int WIDTH         = fifo_pkg::WIDTH,
    parameter int POINTER_WIDTH = fifo_pkg::POINTER_WIDTH,
    parameter int DEPTH         = fifo_pkg::DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    fifo_burst_reader_if.master    bus,
    input  logic [POINTER_WIDTH:0] threshold,
    input  logic [POINTER_WIDTH:0] burst_len,
    input  logic                   flush,
    output logic                   busy,
    output logic                   burst_done
);
    import fifo_pkg::*;

    localparam logic [POINTER_WIDTH:0] MAX_LEN = (POINTER_WIDTH+1)'(DEPTH);

    state_t                 state_q, state_d;
    logic [POINTER_WIDTH:0] remaining_q, remaining_d;
    logic [POINTER_WIDTH:0] size_q, size_d;
    logic [POINTER_WIDTH:0] popped_q, popped_d;
    logic [POINTER_WIDTH:0] popped_inc;
    logic [POINTER_WIDTH:0] len_eff;
    logic                   inflight_q, inflight_d;
    logic [1:0]             occ;
    logic [WIDTH-1:0]       head;
    logic                   issue, pop, credit_ok, can_issue;

    fifo_skid_buf #(.WIDTH(WIDTH)) u_skid_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight_q),
        .push_data (bus.fifo_rd_data),
        .pop       (pop),
        .occ       (occ),
        .head      (head)
    );

    assign pop          = bus.m_valid && bus.m_ready;
    assign bus.m_valid  = occ != 2'd0;
    assign bus.m_data   = head;
    // A read may only be issued if the buffer has room once the in-flight word lands.
    assign credit_ok    = ({1'b0, occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
    assign can_issue    = (state_q == ST_FLUSH) || (state_q == ST_BURST && remaining_q != '0);
    assign bus.fifo_rd_en = can_issue && !bus.fifo_empty && credit_ok;
    assign issue        = bus.fifo_rd_en && !bus.fifo_empty;
    assign inflight_d   = issue;
    assign popped_inc   = popped_q + 1'b1;
    assign busy         = (state_q != ST_IDLE) || (occ != 2'd0) || inflight_q;

    always_comb begin
        len_eff = burst_len;
        if (burst_len == '0)          len_eff = {{POINTER_WIDTH{1'b0}}, 1'b1};
        else if (burst_len > MAX_LEN) len_eff = MAX_LEN;
    end

    // A burst only starts from an empty buffer so popped words map onto this burst alone.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        size_d      = size_q;
        popped_d    = popped_q;
        burst_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flush && !bus.fifo_empty) begin
                    state_d = ST_FLUSH;
                end else if (threshold != '0 && bus.fifo_count >= threshold &&
                             occ == 2'd0 && !inflight_q) begin
                    remaining_d = len_eff;
                    size_d      = len_eff;
                    popped_d    = '0;
                    state_d     = ST_BURST;
                end
            end
            ST_BURST: begin
                if (issue) remaining_d = remaining_q - 1'b1;
                if (pop) begin
                    popped_d   = popped_inc;
                    burst_done = popped_inc == size_q;
                end
                if (remaining_q == '0 && occ == 2'd0 && !inflight_q) state_d = ST_IDLE;
            end
            ST_FLUSH: begin
                if (!flush || (bus.fifo_empty && occ == 2'd0 && !inflight_q)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            size_q      <= '0;
            popped_q    <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            size_q      <= size_d;
            popped_q    <= popped_d;
            inflight_q  <= inflight_d;
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader with a behavioural registered-read FIFO model.
module tb_fifo_burst_reader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       fifo_rst = 1'b1;
    logic [4:0] threshold = '0;
    logic [4:0] burst_len = '0;
    logic       flush = 1'b0;
    logic       busy, burst_done;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;

    fifo_burst_reader_if #(.WIDTH(8), .POINTER_WIDTH(4)) bus ();

    fifo_burst_reader #(.WIDTH(8), .POINTER_WIDTH(4), .DEPTH(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .threshold  (threshold),
        .burst_len  (burst_len),
        .flush      (flush),
        .busy       (busy),
        .burst_done (burst_done)
    );

    always #5 clk = ~clk;

    // FIFO model: 16 deep, read data registered one cycle after an accepted read.
    logic [7:0] fmem [16];
    int         fcount;
    logic [3:0] wptr, rptr;

    always @(posedge clk or posedge fifo_rst) begin : fifo_model
        logic rd_ok, wr_ok;
        if (fifo_rst) begin
            fcount           <= 0;
            wptr             <= '0;
            rptr             <= '0;
            bus.fifo_rd_data <= '0;
        end else begin
            rd_ok = bus.fifo_rd_en && (fcount != 0);
            wr_ok = wr_en && (fcount < 16);
            if (rd_ok) begin
                bus.fifo_rd_data <= fmem[rptr];
                rptr             <= rptr + 4'd1;
            end
            if (wr_ok) begin
                fmem[wptr] <= wr_data;
                wptr       <= wptr + 4'd1;
            end
            fcount <= fcount + int'(wr_ok) - int'(rd_ok);
        end
    end

    assign bus.fifo_count = 5'(fcount);
    assign bus.fifo_empty = (fcount == 0);

    int         cyc = 0;
    logic [7:0] popped [$];
    int         pop_cycles [$];
    int         issue_cycles [$];
    int         issues = 0;
    int         dones = 0;
    int         assert_count = 0;
    int         fail_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.fifo_rd_en && !bus.fifo_empty) begin
                issues = issues + 1;
                issue_cycles.push_back(cyc);
            end
            if (bus.m_valid && bus.m_ready) begin
                popped.push_back(bus.m_data);
                pop_cycles.push_back(cyc);
            end
            if (burst_done) dones = dones + 1;
        end
    end

    typedef struct {
        logic [4:0] threshold;
        logic [4:0] burst_len;
        logic       flush;
        int         n_words;
        logic [7:0] first_word;
        int         exp_drained;
        int         exp_done;
    } vec_t;

    vec_t vecs [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_monitor();
        popped.delete();
        pop_cycles.delete();
        issue_cycles.delete();
        issues = 0;
        dones  = 0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        fifo_rst = 1'b1;
        tick();
        tick();
        reset    = 1'b0;
        fifo_rst = 1'b0;
        tick();
        clear_monitor();
    endtask

    task automatic write_word(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    function automatic logic [7:0] exp_word(input logic [7:0] first, input int i);
        return 8'(int'(first) + i * 17);
    endfunction

    function automatic int q_at(input int q [$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic int popped_at(input int i);
        return (i < popped.size()) ? int'(popped[i]) : -1;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        assert_count = assert_count + 1;
        if (actual != expected) begin
            fail_count = fail_count + 1;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    task automatic check_words(input string name, input logic [7:0] first, input int n);
        checkOutput({name, "_count"}, popped.size(), n);
        for (int i = 0; i < n; i++)
            checkOutput($sformatf("%s_word%0d", name, i), popped_at(i), int'(exp_word(first, i)));
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        do_reset();
        threshold   = '0;
        flush       = 1'b0;
        burst_len   = v.burst_len;
        bus.m_ready = 1'b1;
        for (int i = 0; i < v.n_words; i++) write_word(exp_word(v.first_word, i));
        threshold = v.threshold;
        flush     = v.flush;
        repeat (40) tick();
        check_words($sformatf("vec%0d", idx), v.first_word, v.exp_drained);
        checkOutput($sformatf("vec%0d_done", idx), dones, v.exp_done);
        checkOutput($sformatf("vec%0d_busy", idx), int'(busy), 0);
        flush = 1'b0;
    endtask

    initial begin
        vecs[0] = '{5'd4, 5'd4,  1'b0, 4,  8'h11, 4,  1};
        vecs[1] = '{5'd8, 5'd4,  1'b1, 3,  8'h11, 3,  0};
        vecs[2] = '{5'd8, 5'd4,  1'b0, 3,  8'h11, 0,  0};
        vecs[3] = '{5'd1, 5'd0,  1'b0, 1,  8'hA5, 1,  1};
        vecs[4] = '{5'd0, 5'd4,  1'b0, 5,  8'h11, 0,  0};
        vecs[5] = '{5'd3, 5'd2,  1'b0, 5,  8'h10, 4,  2};
        vecs[6] = '{5'd1, 5'd20, 1'b0, 16, 8'h01, 16, 1};

        bus.m_ready = 1'b0;
        do_reset();
        checkOutput("rst_rd_en",      int'(bus.fifo_rd_en), 0);
        checkOutput("rst_m_valid",    int'(bus.m_valid), 0);
        checkOutput("rst_m_data",     int'(bus.m_data), 0);
        checkOutput("rst_busy",       int'(busy), 0);
        checkOutput("rst_burst_done", int'(burst_done), 0);

        for (int k = 0; k < 7; k++) applyStimulus(vecs[k], k);

        // Back-to-back timing of a 4-word burst.
        do_reset();
        threshold = '0; burst_len = 5'd4; bus.m_ready = 1'b1;
        for (int i = 0; i < 4; i++) write_word(exp_word(8'h11, i));
        threshold = 5'd4;
        repeat (20) tick();
        checkOutput("tim_issues", issues, 4);
        checkOutput("tim_issue_span", q_at(issue_cycles, 3) - q_at(issue_cycles, 0), 3);
        checkOutput("tim_pop_span", q_at(pop_cycles, 3) - q_at(pop_cycles, 0), 3);
        checkOutput("tim_latency", q_at(pop_cycles, 0) - q_at(issue_cycles, 0), 2);
        check_words("tim", 8'h11, 4);
        checkOutput("tim_done", dones, 1);

        // Downstream backpressure holds data and limits outstanding reads.
        do_reset();
        threshold = '0; burst_len = 5'd4; bus.m_ready = 1'b0;
        for (int i = 0; i < 4; i++) write_word(exp_word(8'h11, i));
        threshold = 5'd4;
        for (int i = 0; i < 20 && !bus.m_valid; i++) tick();
        checkOutput("bp_valid_seen", int'(bus.m_valid), 1);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("bp_hold_data%0d", i), int'(bus.m_data), 8'h11);
            checkOutput($sformatf("bp_hold_valid%0d", i), int'(bus.m_valid), 1);
            tick();
        end
        checkOutput("bp_reads_le2", int'(issues <= 2), 1);
        bus.m_ready = 1'b1;
        repeat (20) tick();
        check_words("bp", 8'h11, 4);
        checkOutput("bp_done", dones, 1);

        // FIFO runs dry mid-burst; reader waits in BURST.
        do_reset();
        threshold = '0; burst_len = 5'd6; bus.m_ready = 1'b1;
        write_word(8'h11); write_word(8'h22);
        threshold = 5'd2;
        repeat (10) tick();
        checkOutput("stall_drained2", popped.size(), 2);
        checkOutput("stall_busy", int'(busy), 1);
        write_word(8'h33); write_word(8'h44); write_word(8'h55);
        repeat (20) tick();
        checkOutput("stall_drained5", popped.size(), 5);
        checkOutput("stall_busy5", int'(busy), 1);
        checkOutput("stall_no_done", dones, 0);
        write_word(8'h66);
        repeat (20) tick();
        check_words("stall", 8'h11, 6);
        checkOutput("stall_done", dones, 1);
        checkOutput("stall_idle", int'(busy), 0);

        // Asynchronous reset with a full buffer mid-burst.
        do_reset();
        threshold = '0; burst_len = 5'd4; bus.m_ready = 1'b0;
        for (int i = 0; i < 4; i++) write_word(exp_word(8'h11, i));
        threshold = 5'd4;
        for (int i = 0; i < 20 && !bus.m_valid; i++) tick();
        tick(); tick();
        #2;
        reset = 1'b1;
        #1;
        checkOutput("arst_m_valid", int'(bus.m_valid), 0);
        checkOutput("arst_rd_en",   int'(bus.fifo_rd_en), 0);
        checkOutput("arst_busy",    int'(busy), 0);
        tick();
        reset = 1'b0;
        tick();
        clear_monitor();
        bus.m_ready = 1'b1;
        repeat (15) tick();
        checkOutput("arst_no_reads", issues, 0);
        write_word(8'h55); write_word(8'h66);
        repeat (20) tick();
        check_words("arst", 8'h33, 4);
        checkOutput("arst_done", dones, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
